// File: rtl/pipe_ctrl_pkg.sv
// Shared control-bundle type, branch/forward encodings and file-match helper
// for the ID->WB pipeline control slice.
package pipe_ctrl_pkg;

  localparam int CTRL_W = 14;

  typedef struct packed {
    logic [2:0] alu_ctrl_op;
    logic       alu_rs2_sel;
    logic       exe_pc_sel;
    logic       mem_rd_sel;
    logic       din_sel;
    logic       dm_read;
    logic       dm_write;
    logic       reg_file_write;
    logic       reg_file_fp_write;
    logic       wb_data_sel;
    logic [1:0] branch_signal;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_BUBBLE = {CTRL_W{1'b0}};

  localparam logic [1:0] N_Branch   = 2'b00;
  localparam logic [1:0] JAL_Branch = 2'b01;
  localparam logic [1:0] B_Branch   = 2'b10;
  localparam logic [1:0] J_Branch   = 2'b11;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Picks the write enable that targets the file the source operand reads.
  function automatic logic file_write(input logic int_wr, input logic fp_wr,
                                      input logic src_fp);
    return src_fp ? fp_wr : int_wr;
  endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// EX operand forwarding comparator: picks MEM, WB or the register file for
// one source operand.
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  use_src,
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  src_fp,
  input  logic                  mem_valid,
  input  logic                  mem_int_wr,
  input  logic                  mem_fp_wr,
  input  logic                  mem_load,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  wb_valid,
  input  logic                  wb_int_wr,
  input  logic                  wb_fp_wr,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            fwd_sel
);

  logic src_real_s;
  logic mem_hit_s;
  logic wb_hit_s;

  // x0 is hardwired zero, but f0 is an ordinary FP register.
  assign src_real_s = src_fp | (|src);

  // A load still in MEM has no data yet; load-use stalls keep it out of here.
  assign mem_hit_s = use_src & src_real_s & mem_valid & ~mem_load &
                     file_write(mem_int_wr, mem_fp_wr, src_fp) & (mem_rd == src);
  assign wb_hit_s  = use_src & src_real_s & wb_valid &
                     file_write(wb_int_wr, wb_fp_wr, src_fp) & (wb_rd == src);

  // Younger producer (MEM) takes priority over WB.
  always_comb begin
    if (mem_hit_s) begin
      fwd_sel = FWD_MEM;
    end else if (wb_hit_s) begin
      fwd_sel = FWD_WB;
    end else begin
      fwd_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control: carries decoded control through EX/MEM/WB, inserts
// load-use and flush bubbles, freezes on memory wait, drives forwarding.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_branch_taken,
  input  logic                  mem_stall,
  output logic                  if_stall,
  output logic                  ifid_flush,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic [CTRL_W-1:0]     mem_ctrl,
  output logic [CTRL_W-1:0]     wb_ctrl,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [1:0]            fwd_rs1_sel,
  output logic [1:0]            fwd_rs2_sel
);

  ctrl_bundle_t          id_bundle_s;
  ctrl_bundle_t          ex_ctrl_r, mem_ctrl_r, wb_ctrl_r;
  logic                  ex_valid_r, mem_valid_r, wb_valid_r;
  logic [REG_ADDR_W-1:0] ex_rd_r, mem_rd_r, wb_rd_r;
  logic [REG_ADDR_W-1:0] ex_rs1_r, ex_rs2_r;
  logic                  ex_use_rs1_r, ex_use_rs2_r;
  logic                  flush_pend_r;
  logic                  rs1_hit_s, rs2_hit_s;
  logic                  load_use_s, flush_s, id_take_s;

  assign id_bundle_s = id_ctrl;

  // Load-use: the instruction in EX is a load whose result ID needs now.
  assign rs1_hit_s  = id_use_rs1 & (|id_rs1) & ex_ctrl_r.reg_file_write &
                      (ex_rd_r == id_rs1);
  assign rs2_hit_s  = id_use_rs2 & (id_bundle_s.din_sel | (|id_rs2)) &
                      file_write(ex_ctrl_r.reg_file_write, ex_ctrl_r.reg_file_fp_write,
                                 id_bundle_s.din_sel) &
                      (ex_rd_r == id_rs2);
  assign load_use_s = id_valid & ex_valid_r & ex_ctrl_r.dm_read & (rs1_hit_s | rs2_hit_s);

  // A redirect seen during a memory wait is remembered until the pipe moves.
  assign flush_s    = rst_n & ~mem_stall & (ex_branch_taken | flush_pend_r);
  assign if_stall   = rst_n & (mem_stall | (load_use_s & ~flush_s));
  assign ifid_flush = flush_s;
  assign id_take_s  = id_valid & ~flush_s & ~load_use_s;

  // Redirect pending across a memory-wait freeze.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_pend_r <= 1'b0;
    end else begin
      flush_pend_r <= mem_stall & (flush_pend_r | ex_branch_taken);
    end
  end

  // Stage registers: hold on memory wait, otherwise advance one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r   <= 1'b0;
      ex_ctrl_r    <= CTRL_BUBBLE;
      ex_rd_r      <= {REG_ADDR_W{1'b0}};
      ex_rs1_r     <= {REG_ADDR_W{1'b0}};
      ex_rs2_r     <= {REG_ADDR_W{1'b0}};
      ex_use_rs1_r <= 1'b0;
      ex_use_rs2_r <= 1'b0;
      mem_valid_r  <= 1'b0;
      mem_ctrl_r   <= CTRL_BUBBLE;
      mem_rd_r     <= {REG_ADDR_W{1'b0}};
      wb_valid_r   <= 1'b0;
      wb_ctrl_r    <= CTRL_BUBBLE;
      wb_rd_r      <= {REG_ADDR_W{1'b0}};
    end else if (!mem_stall) begin
      ex_valid_r   <= id_take_s;
      ex_ctrl_r    <= id_take_s ? id_bundle_s : CTRL_BUBBLE;
      ex_rd_r      <= id_take_s ? id_rd  : {REG_ADDR_W{1'b0}};
      ex_rs1_r     <= id_take_s ? id_rs1 : {REG_ADDR_W{1'b0}};
      ex_rs2_r     <= id_take_s ? id_rs2 : {REG_ADDR_W{1'b0}};
      ex_use_rs1_r <= id_take_s & id_use_rs1;
      ex_use_rs2_r <= id_take_s & id_use_rs2;
      mem_valid_r  <= ex_valid_r;
      mem_ctrl_r   <= ex_ctrl_r;
      mem_rd_r     <= ex_rd_r;
      wb_valid_r   <= mem_valid_r;
      wb_ctrl_r    <= mem_ctrl_r;
      wb_rd_r      <= mem_rd_r;
    end
  end

  assign ex_ctrl  = ex_ctrl_r;
  assign mem_ctrl = mem_ctrl_r;
  assign wb_ctrl  = wb_ctrl_r;
  assign ex_rd    = ex_rd_r;
  assign mem_rd   = mem_rd_r;
  assign wb_rd    = wb_rd_r;

  pipe_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .use_src    (ex_use_rs1_r),
    .src        (ex_rs1_r),
    .src_fp     (1'b0),
    .mem_valid  (mem_valid_r),
    .mem_int_wr (mem_ctrl_r.reg_file_write),
    .mem_fp_wr  (mem_ctrl_r.reg_file_fp_write),
    .mem_load   (mem_ctrl_r.dm_read),
    .mem_rd     (mem_rd_r),
    .wb_valid   (wb_valid_r),
    .wb_int_wr  (wb_ctrl_r.reg_file_write),
    .wb_fp_wr   (wb_ctrl_r.reg_file_fp_write),
    .wb_rd      (wb_rd_r),
    .fwd_sel    (fwd_rs1_sel)
  );

  pipe_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .use_src    (ex_use_rs2_r),
    .src        (ex_rs2_r),
    .src_fp     (ex_ctrl_r.din_sel),
    .mem_valid  (mem_valid_r),
    .mem_int_wr (mem_ctrl_r.reg_file_write),
    .mem_fp_wr  (mem_ctrl_r.reg_file_fp_write),
    .mem_load   (mem_ctrl_r.dm_read),
    .mem_rd     (mem_rd_r),
    .wb_valid   (wb_valid_r),
    .wb_int_wr  (wb_ctrl_r.reg_file_write),
    .wb_fp_wr   (wb_ctrl_r.reg_file_fp_write),
    .wb_rd      (wb_rd_r),
    .fwd_sel    (fwd_rs2_sel)
  );

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: directed hazard scenarios followed
// by random traffic, all compared against an instruction-level pipeline model.
module tb_pipe_ctrl_unit;

  localparam int AW = 5;
  localparam int CW = 14;
  // Control-bundle bit positions (MSB first: alu[2:0], rs2_sel, pc_sel,
  // mem_rd_sel, din_sel, dm_read, dm_write, rf_w, fp_w, wb_sel, br[1:0]).
  localparam int DIN = 7;
  localparam int DMR = 6;
  localparam int RFW = 4;
  localparam int FPW = 3;

  localparam logic [CW-1:0] C_LW   = 14'b000_1_0_0_0_1_0_1_0_1_00;
  localparam logic [CW-1:0] C_FLW  = 14'b000_1_0_0_0_1_0_0_1_1_00;
  localparam logic [CW-1:0] C_ADD  = 14'b000_0_0_0_0_0_0_1_0_0_00;
  localparam logic [CW-1:0] C_ADDI = 14'b000_1_0_0_0_0_0_1_0_0_00;
  localparam logic [CW-1:0] C_FSW  = 14'b000_1_0_0_1_0_1_0_0_0_00;
  localparam logic [CW-1:0] C_JAL  = 14'b000_0_1_0_0_0_0_1_0_0_01;

  typedef struct {
    bit            valid;
    logic [CW-1:0] ctrl;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    bit            use1;
    bit            use2;
  } instr_t;

  logic          clk;
  logic          rst_n;
  logic          id_valid;
  logic [CW-1:0] id_ctrl;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2;
  logic          ex_branch_taken, mem_stall;
  logic          if_stall, ifid_flush;
  logic [CW-1:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [AW-1:0] ex_rd, mem_rd, wb_rd;
  logic [1:0]    fwd_rs1_sel, fwd_rs2_sel;

  pipe_ctrl_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_ctrl         (id_ctrl),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_rd           (id_rd),
    .ex_branch_taken (ex_branch_taken),
    .mem_stall       (mem_stall),
    .if_stall        (if_stall),
    .ifid_flush      (ifid_flush),
    .ex_ctrl         (ex_ctrl),
    .mem_ctrl        (mem_ctrl),
    .wb_ctrl         (wb_ctrl),
    .ex_rd           (ex_rd),
    .mem_rd          (mem_rd),
    .wb_rd           (wb_rd),
    .fwd_rs1_sel     (fwd_rs1_sel),
    .fwd_rs2_sel     (fwd_rs2_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Reference pipeline: one instruction record per stage.
  instr_t m_ex, m_mem, m_wb;
  bit     m_pend;

  // Values captured at the last check point, for scenario-specific checks.
  bit            exp_stall_g;
  logic          g_stall, g_flush;
  logic [CW-1:0] g_ex_ctrl, g_mem_ctrl;
  logic [1:0]    g_fwd1, g_fwd2;

  function automatic instr_t nop_i();
    instr_t i;
    i.valid = 1'b0; i.ctrl = '0; i.rd = '0; i.rs1 = '0; i.rs2 = '0;
    i.use1 = 1'b0; i.use2 = 1'b0;
    return i;
  endfunction

  function automatic instr_t mk(input logic [CW-1:0] c, input logic [AW-1:0] rd,
                                input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                                input bit u1, input bit u2);
    instr_t i;
    i.valid = 1'b1; i.ctrl = c; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    i.use1 = u1; i.use2 = u2;
    return i;
  endfunction

  // Does stage record s write register a of the selected file?
  function automatic bit writes(input instr_t s, input logic [AW-1:0] a, input bit fp);
    bit wr;
    wr = fp ? (s.ctrl[FPW] == 1'b1) : ((s.ctrl[RFW] == 1'b1) && (a != 0));
    return s.valid && wr && (s.rd == a);
  endfunction

  function automatic bit model_load_use(input instr_t id);
    bit h1, h2;
    h1 = id.use1 && writes(m_ex, id.rs1, 1'b0);
    h2 = id.use2 && writes(m_ex, id.rs2, id.ctrl[DIN] == 1'b1);
    return id.valid && m_ex.valid && (m_ex.ctrl[DMR] == 1'b1) && (h1 || h2);
  endfunction

  function automatic logic [1:0] model_fwd(input bit u, input logic [AW-1:0] a, input bit fp);
    if (u && writes(m_mem, a, fp) && (m_mem.ctrl[DMR] == 1'b0)) return 2'b01;
    if (u && writes(m_wb, a, fp)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ex = nop_i(); m_mem = nop_i(); m_wb = nop_i(); m_pend = 1'b0;
    exp_stall_g = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_stall"}, 32'(if_stall), 32'd0);
    chk({tag, "_ifid_flush"}, 32'(ifid_flush), 32'd0);
    chk({tag, "_ex_ctrl"}, 32'(ex_ctrl), 32'd0);
    chk({tag, "_mem_ctrl"}, 32'(mem_ctrl), 32'd0);
    chk({tag, "_wb_ctrl"}, 32'(wb_ctrl), 32'd0);
    chk({tag, "_ex_rd"}, 32'(ex_rd), 32'd0);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
    chk({tag, "_fwd1"}, 32'(fwd_rs1_sel), 32'd0);
    chk({tag, "_fwd2"}, 32'(fwd_rs2_sel), 32'd0);
  endtask

  // One cycle: drive ID/hazard inputs, check every output, then advance model.
  task automatic step(input instr_t id, input bit br, input bit ms);
    bit lu, fl, st;
    @(negedge clk);
    id_valid = id.valid; id_ctrl = id.ctrl; id_rd = id.rd;
    id_rs1 = id.rs1; id_rs2 = id.rs2; id_use_rs1 = id.use1; id_use_rs2 = id.use2;
    ex_branch_taken = br; mem_stall = ms;
    #1;
    lu = model_load_use(id);
    fl = (br || m_pend) && !ms;
    st = ms || (lu && !fl);
    chk("if_stall", 32'(if_stall), 32'(st));
    chk("ifid_flush", 32'(ifid_flush), 32'(fl));
    chk("ex_ctrl", 32'(ex_ctrl), 32'(m_ex.ctrl));
    chk("mem_ctrl", 32'(mem_ctrl), 32'(m_mem.ctrl));
    chk("wb_ctrl", 32'(wb_ctrl), 32'(m_wb.ctrl));
    chk("ex_rd", 32'(ex_rd), 32'(m_ex.rd));
    chk("mem_rd", 32'(mem_rd), 32'(m_mem.rd));
    chk("wb_rd", 32'(wb_rd), 32'(m_wb.rd));
    chk("fwd_rs1", 32'(fwd_rs1_sel), 32'(model_fwd(m_ex.use1, m_ex.rs1, 1'b0)));
    chk("fwd_rs2", 32'(fwd_rs2_sel), 32'(model_fwd(m_ex.use2, m_ex.rs2, m_ex.ctrl[DIN] == 1'b1)));
    g_stall = if_stall; g_flush = ifid_flush; g_ex_ctrl = ex_ctrl; g_mem_ctrl = mem_ctrl;
    g_fwd1 = fwd_rs1_sel; g_fwd2 = fwd_rs2_sel;
    exp_stall_g = st;
    @(posedge clk);
    if (ms) begin
      m_pend = m_pend || br;
    end else begin
      m_pend = 1'b0;
      m_wb   = m_mem;
      m_mem  = m_ex;
      m_ex   = (fl || lu || !id.valid) ? nop_i() : id;
    end
  endtask

  initial begin
    instr_t cur;
    rst_n = 1'b0; id_valid = 1'b0; id_ctrl = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_branch_taken = 1'b0; mem_stall = 1'b0;
    model_reset();
    #12;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Load-use: LW x5 ; ADD x6,x5,x1 -> one stall, bubble, then WB forward.
    step(mk(C_LW, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0), 1'b0, 1'b0);
    step(mk(C_ADD, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1), 1'b0, 1'b0);
    chk("lu_stall", 32'(g_stall), 32'd1);
    step(mk(C_ADD, 5'd6, 5'd5, 5'd1, 1'b1, 1'b1), 1'b0, 1'b0);
    chk("lu_bubble_ex", 32'(g_ex_ctrl), 32'd0);
    chk("lu_single_stall", 32'(g_stall), 32'd0);
    step(nop_i(), 1'b0, 1'b0);
    chk("lu_fwd_wb", 32'(g_fwd1), 32'd2);

    // FP f0 hazard stalls; integer x0 never does.
    step(mk(C_FLW, 5'd0, 5'd2, 5'd0, 1'b1, 1'b0), 1'b0, 1'b0);
    step(mk(C_FSW, 5'd0, 5'd2, 5'd0, 1'b1, 1'b1), 1'b0, 1'b0);
    chk("fp_f0_stall", 32'(g_stall), 32'd1);
    step(mk(C_FSW, 5'd0, 5'd2, 5'd0, 1'b1, 1'b1), 1'b0, 1'b0);
    step(mk(C_LW, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0), 1'b0, 1'b0);
    step(mk(C_ADD, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1), 1'b0, 1'b0);
    chk("x0_no_stall", 32'(g_stall), 32'd0);

    // Forward priority: MEM beats WB.
    step(mk(C_ADDI, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0), 1'b0, 1'b0);
    step(mk(C_ADDI, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0), 1'b0, 1'b0);
    step(mk(C_ADD, 5'd4, 5'd3, 5'd3, 1'b1, 1'b1), 1'b0, 1'b0);
    step(nop_i(), 1'b0, 1'b0);
    chk("prio_fwd1", 32'(g_fwd1), 32'd1);
    chk("prio_fwd2", 32'(g_fwd2), 32'd1);

    // Flush overrides a simultaneous load-use.
    step(mk(C_LW, 5'd7, 5'd1, 5'd0, 1'b1, 1'b0), 1'b0, 1'b0);
    step(mk(C_ADD, 5'd8, 5'd7, 5'd0, 1'b1, 1'b1), 1'b1, 1'b0);
    chk("flush_vs_lu_flush", 32'(g_flush), 32'd1);
    chk("flush_vs_lu_stall", 32'(g_stall), 32'd0);
    step(nop_i(), 1'b0, 1'b0);
    chk("flush_ex_bubble", 32'(g_ex_ctrl), 32'd0);
    step(nop_i(), 1'b0, 1'b0);
    chk("flush_mem_bubble", 32'(g_mem_ctrl), 32'd0);

    // Memory wait during a taken JAL: freeze, then a single delayed flush.
    step(mk(C_JAL, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(nop_i(), 1'b1, 1'b1);
      chk("ms_no_flush", 32'(g_flush), 32'd0);
      chk("ms_ex_frozen", 32'(g_ex_ctrl), 32'(C_JAL));
    end
    step(nop_i(), 1'b1, 1'b0);
    chk("ms_drop_flush", 32'(g_flush), 32'd1);
    step(nop_i(), 1'b0, 1'b0);
    chk("ms_flush_once", 32'(g_flush), 32'd0);

    // Asynchronous reset mid-stream, then first instruction one cycle later.
    step(mk(C_ADDI, 5'd2, 5'd1, 5'd0, 1'b1, 1'b0), 1'b0, 1'b0);
    step(mk(C_ADDI, 5'd3, 5'd2, 5'd0, 1'b1, 1'b0), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    model_reset();
    #1 rst_n = 1'b1;
    step(mk(C_ADDI, 5'd9, 5'd1, 5'd0, 1'b1, 1'b0), 1'b0, 1'b0);
    step(nop_i(), 1'b0, 1'b0);
    chk("rst_first_ex", 32'(g_ex_ctrl), 32'(C_ADDI));

    // Random traffic on a small register window to force collisions.
    cur = nop_i();
    for (int n = 0; n < 400; n++) begin
      if (!exp_stall_g) begin
        cur.valid = ($urandom_range(0, 99) < 85);
        cur.ctrl  = CW'($urandom_range(0, 16383));
        cur.rd    = AW'($urandom_range(0, 3));
        cur.rs1   = AW'($urandom_range(0, 3));
        cur.rs2   = AW'($urandom_range(0, 3));
        cur.use1  = ($urandom_range(0, 3) != 0);
        cur.use2  = ($urandom_range(0, 1) != 0);
      end
      step(cur, ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) < 15));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
Consumer end of the ID-stage control decode. It takes the decoded control bundle and register addresses, then carries them through the EX, MEM and WB pipeline registers. It also detects load-use hazards, applies branch/jump flushes and memory-wait freezes, and produces operand-forwarding selects for EX. The block sits between the decoder and the EX/MEM/WB datapath registers.

Parameters:
REG_ADDR_W, 5, register-address width for both the integer and FP files
CTRL_W, 14, packed control-bundle width (fixed; also exported from the package)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
id_valid  in  1  ID holds a real instruction
id_ctrl  in  CTRL_W  {ALU_Ctrl_op[2:0], ALU_rs2_sel, EXE_pc_sel, MEM_rd_sel, Din_sel, DM_read, DM_write, reg_file_write, reg_file_FP_write, WB_data_sel, branch_signal[1:0]}
id_rs1  in  REG_ADDR_W  rs1 address (always integer file)
id_rs2  in  REG_ADDR_W  rs2 address (FP file when id_ctrl.Din_sel=1)
id_use_rs1 / id_use_rs2  in  1 each  operand actually read
id_rd  in  REG_ADDR_W  destination address
ex_branch_taken  in  1  EX resolved a redirect (taken B, JAL, JALR)
mem_stall  in  1  IM/DM wait; freeze the whole pipe
if_stall  out  1  hold PC and the IF/ID register
ifid_flush  out  1  squash the IF/ID register
ex_ctrl / mem_ctrl / wb_ctrl  out  CTRL_W each  per-stage control; zero when the stage is invalid
ex_rd / mem_rd / wb_rd  out  REG_ADDR_W each  per-stage destination address
fwd_rs1_sel / fwd_rs2_sel  out  2 each  EX operand source: 00 regfile, 01 MEM stage, 10 WB stage

Behaviour:
- Reset (async, rst_n=0):
  - All stage valid bits, ctrl and rd fields, and the EX rs1/rs2 copies go to 0.
  - if_stall=0, ifid_flush=0, fwd_*=00.
  - Reset mid-operation discards all in-flight state immediately.
- Stage registers {valid, ctrl, rd, rs1, rs2, use bits, rs2_fp}: ID→EX→MEM→WB, 1 cycle per stage on each enabled edge.
- Destination file per stage: int when ctrl.reg_file_write, FP when ctrl.reg_file_FP_write.
- Int-file matches on x0 never count. FP f0 is a real register and does match.
- Load-use (combinational): id_valid & ex.valid & ex.DM_read, and (id_use_rs1 & ex int-dest & ex_rd==id_rs1, or id_use_rs2 & file-matched ex dest & ex_rd==id_rs2).
  - Result: if_stall=1 and a bubble (valid=0, ctrl=0) enters EX. MEM and WB advance.
  - Exactly one stall cycle; the load then reaches WB and is forwarded.
- Flush: ex_branch_taken & ~mem_stall gives ifid_flush=1 and a bubble into EX.
  - Flush overrides load-use; if_stall=0 that cycle.
- mem_stall=1:
  - if_stall=1, ifid_flush=0; every stage register holds.
  - A pending flush or stall takes effect on the first cycle after mem_stall drops.
- Priority: mem_stall > flush > load-use > normal advance.
- Forwarding for EX rs1/rs2, when the use bit is set:
  - Select 01 if MEM valid, dest file matches and rd matches.
  - Else select 10 if WB matches the same way.
  - Else 00. MEM wins over WB.
  - A MEM-stage DM_read is never selected as 01; load-use prevents that case.
- ex_ctrl/mem_ctrl/wb_ctrl are registered outputs with 0 latency from stage entry. Bubbles carry all-zero ctrl, so there are no stray writes.

Decomposition:
- Package pipe_ctrl_pkg:
  - ctrl_bundle_t packed struct with the field order above, and CTRL_W.
  - Branch-type constants N_Branch=00, JAL_Branch=01, B_Branch=10, J_Branch=11.
  - Forward-select constants FWD_RF, FWD_MEM, FWD_WB.
- One sub-module, pipe_fwd_unit: the combinational forwarding comparator, instantiated once per EX operand.

Test Plan:
- Load-use: LW x5 followed by ADD x6,x5,x1 → one cycle with if_stall=1, a zero-ctrl bubble in EX, then fwd_rs1_sel=10 when the ADD is in EX.
- FP hazard: FLW f0 followed by FSW f0,0(x2) → stall asserted (f0 matches). Repeat with LW x0 then ADD x1,x0,x0 → no stall.
- Forward priority: ADDI x3 twice back-to-back, then ADD x4,x3,x3 → fwd_rs1_sel=fwd_rs2_sel=01, not 10.
- Flush vs load-use: ex_branch_taken=1 in the same cycle load-use is detected → ifid_flush=1, if_stall=0, EX bubble; the younger instruction never reaches MEM.
- mem_stall: hold mem_stall=1 for 3 cycles during a taken JAL → all stage outputs frozen, ifid_flush=0. On the drop cycle ifid_flush=1 for exactly 1 cycle.
- Reset: assert rst_n=0 mid-stream, asynchronously between clock edges → all outputs 0 immediately. After release, the first instruction appears in ex_ctrl one cycle after id_valid.
